// File: rtl/window_stats.sv
// Windowed sum/average/min/max over WINDOW unsigned samples, with a valid/ready
// handshake on both sides and a single registered result slot.
module window_stats #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned WINDOW = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NBITS-1:0]                  XIN,
  input  logic                              XIN_VALID,
  output logic                              XIN_READY,
  output logic [NBITS+$clog2(WINDOW)-1:0]   SUM,
  output logic [NBITS-1:0]                  AVG,
  output logic [NBITS-1:0]                  XMIN,
  output logic [NBITS-1:0]                  XMAX,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY
);

  localparam int unsigned LW = $clog2(WINDOW);
  localparam int unsigned SW = NBITS + LW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state;
  logic [LW-1:0]     count;
  logic [SW-1:0]     acc_sum;
  logic [NBITS-1:0]  acc_min;
  logic [NBITS-1:0]  acc_max;

  logic              out_free;
  logic              last_slot;
  logic              accept;
  logic [SW-1:0]     nxt_sum;
  logic [NBITS-1:0]  nxt_min;
  logic [NBITS-1:0]  nxt_max;

  // Result slot can take a new value when empty or being drained this cycle.
  always_comb begin
    out_free  = !OUT_VALID || OUT_READY;
    last_slot = (count == LW'(WINDOW - 1));
    XIN_READY = 1'b0;
    if (RST_N) begin
      case (state)
        EMPTY:   XIN_READY = 1'b1;
        ACCUM:   XIN_READY = !last_slot || out_free;
        default: XIN_READY = 1'b0;
      endcase
    end
    accept  = XIN_VALID && XIN_READY;
    nxt_sum = acc_sum + SW'(XIN);
    nxt_min = (XIN < acc_min) ? XIN : acc_min;
    nxt_max = (XIN > acc_max) ? XIN : acc_max;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= EMPTY;
      count     <= '0;
      acc_sum   <= '0;
      acc_min   <= '0;
      acc_max   <= '0;
      SUM       <= '0;
      AVG       <= '0;
      XMIN      <= '0;
      XMAX      <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      // Drain first; a same-cycle reload below overrides the clear.
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            acc_sum <= SW'(XIN);
            acc_min <= XIN;
            acc_max <= XIN;
            count   <= LW'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_slot) begin
              SUM       <= nxt_sum;
              AVG       <= NBITS'(nxt_sum >> LW);
              XMIN      <= nxt_min;
              XMAX      <= nxt_max;
              OUT_VALID <= 1'b1;
              count     <= '0;
              state     <= EMPTY;
            end else begin
              acc_sum <= nxt_sum;
              acc_min <= nxt_min;
              acc_max <= nxt_max;
              count   <= LW'(count + LW'(1));
            end
          end
        end
        STALL: begin
          // Completed window parked in the accumulators until the slot frees.
          if (out_free) begin
            SUM       <= acc_sum;
            AVG       <= NBITS'(acc_sum >> LW);
            XMIN      <= acc_min;
            XMAX      <= acc_max;
            OUT_VALID <= 1'b1;
            count     <= '0;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/window_stats.md
WINDOW_STATS -- requirements
Module: window_stats

Interface
REQ-001 SHALL provide parameter NBITS, default 8: sample width, matching the upstream XOUT width.
REQ-002 SHALL provide parameter WINDOW, default 4: samples per window; power of two, 2..256.
REQ-003 SHALL derive local constant LW = log2(WINDOW); SUM width = NBITS + LW.
REQ-004 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port XIN  in  NBITS  unsigned sample, driven by the upstream XOUT.
REQ-007 SHALL have port XIN_VALID  in  1  XIN holds a valid sample this cycle.
REQ-008 SHALL have port XIN_READY  out  1  block accepts XIN this cycle.
REQ-009 SHALL have port SUM  out  NBITS+LW  unsigned sum of the completed window.
REQ-010 SHALL have port AVG  out  NBITS  SUM >> LW, truncated.
REQ-011 SHALL have port XMIN  out  NBITS  minimum sample of the completed window.
REQ-012 SHALL have port XMAX  out  NBITS  maximum sample of the completed window.
REQ-013 SHALL have port OUT_VALID  out  1  SUM, AVG, XMIN and XMAX hold a result.
REQ-014 SHALL have port OUT_READY  in  1  downstream consumes the result this cycle.

Function
REQ-015 SHALL accept a sample iff XIN_VALID && XIN_READY at the clock edge; no other condition accepts a sample.
REQ-016 SHALL implement an FSM with three states:
- EMPTY: count = 0.
- ACCUM: 0 < count < WINDOW.
- STALL: window complete, result not yet transferred.
REQ-017 EMPTY, on accept: acc_sum = XIN, acc_min = acc_max = XIN, count = 1, next state ACCUM.
REQ-018 ACCUM, on accept with count < WINDOW-1: acc_sum += XIN (no overflow at full width); update acc_min and acc_max; count += 1.
REQ-019 ACCUM, on accept with count == WINDOW-1 (final sample), when the output register is free:
- Load the output registers with the final-inclusive sum, min, max and AVG.
- Set OUT_VALID = 1 on the next cycle (1-cycle latency from final accept).
- Next state EMPTY.
REQ-020 Output register is free when OUT_VALID == 0, or when OUT_VALID == 1 && OUT_READY == 1 in the same cycle; a simultaneous handoff and reload SHALL lose no result.
REQ-021 ACCUM with count == WINDOW-1 and output register not free: XIN_READY = 0 (backpressure); no sample accepted.
REQ-022 STALL SHALL be entered only if the internal window completes while the output is blocked; XIN_READY = 0 in STALL; on the output becoming free, load the result and go to EMPTY.
REQ-023 XIN_READY = 1 in EMPTY; in ACCUM, XIN_READY = 1 except per REQ-021; XIN_READY SHALL be combinational from state, count, OUT_VALID and OUT_READY only, never from XIN_VALID.
REQ-024 OUT_VALID && !OUT_READY SHALL hold SUM, AVG, XMIN, XMAX and OUT_VALID stable.
REQ-025 OUT_VALID && OUT_READY with no new result loading SHALL clear OUT_VALID next cycle; the data outputs keep their values.
REQ-026 XIN_VALID gaps SHALL not disturb the accumulators or count.
REQ-027 Min/max comparisons SHALL be unsigned; on ties, the value is unchanged.

Reset
REQ-028 RST_N low SHALL immediately force:
- state EMPTY, count 0, acc_* 0;
- SUM = 0, AVG = 0, XMIN = 0, XMAX = 0, OUT_VALID = 0.
REQ-029 Reset asserted mid-window SHALL discard the partial window; the first accept after release starts a fresh window.
REQ-030 XIN_READY SHALL be 0 while RST_N is low, and 1 from the first cycle after release.

Verification (NBITS=8, WINDOW=4, OUT_READY=1 unless stated)
REQ-031 Samples 10,20,30,40 back-to-back -> cycle after 40 accepted: OUT_VALID=1, SUM=100, AVG=25, XMIN=10, XMAX=40.
REQ-032 Four samples of 255 -> SUM=1020 (10-bit, no wrap), AVG=255, XMIN=XMAX=255.
REQ-033 Samples 7,3,9,3 with XIN_VALID low for 2 cycles between each -> SUM=22, AVG=5, XMIN=3, XMAX=9; single OUT_VALID pulse.
REQ-034 OUT_READY=0; window 1,2,3,4, then window 5,6,7 plus final 8 offered -> XIN_READY=0 on the final 8; result 1..4 held stable (SUM=10); raise OUT_READY -> 8 accepted same cycle; next cycle SUM=26, XMIN=5, XMAX=8.
REQ-035 Accept 50,60, assert RST_N low asynchronously mid-cycle -> outputs 0 at once; after release, window 1,1,1,1 -> SUM=4, AVG=1.
REQ-036 Continuous stream 0..11 with OUT_READY=1 -> three results, SUM=6,22,38, no dropped samples, XIN_READY constantly 1.
